// File: rtl/apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl
//
// APB requester. Accepts one read/write command at a time on a local
// valid/ready port, runs the APB SETUP -> ACCESS handshake, waits for PREADY
// and returns read data plus error status as a single-cycle response pulse.
// A wait-state watchdog aborts a transfer the completer stalls for too long.
//
// Parameters
//   ADDR_W    width of cmd_addr / PADDR
//   DATA_W    width of cmd_wdata / PWDATA / PRDATA / rsp_rdata
//   TIMEOUT   max ACCESS cycles with PREADY=0 before abort (0 = no watchdog)
//
// Ports
//   PCLK, PRESETn          bus clock, asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_write              1 = write, 0 = read
//   cmd_addr, cmd_wdata    command address and write data
//   rsp_valid              one-cycle completion pulse, no backpressure
//   rsp_rdata              read data (0 for writes and aborted transfers)
//   rsp_err                PSLVERR at completion, or 1 on watchdog abort
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request signals
//   PRDATA, PREADY, PSLVERR                APB completer signals
// ----------------------------------------------------------------------------
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // Fixed encoding so the unused code 11 can be recognised and recovered.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SETUP   = 2'b01,
        ACCESS  = 2'b10,
        BADCODE = 2'b11
    } state_e;

    // The counter only has to reach TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the watchdog is disabled or TIMEOUT is 1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e              state_q,     state_d;
    logic                pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;

    // Next-state logic. Every register holds by default; rsp_valid defaults
    // low so it can only ever be a single-cycle pulse following a completion.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                // Address/control are latched here so they stay stable for the
                // whole transfer regardless of what the command port does.
                if (cmd_valid) begin
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    wait_cnt_d = '0;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                state_d = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                    // Watchdog abort: report an error with no data.
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the bus immediately and
    // discards any transfer in flight without a response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Handshake and APB phase signals decode straight from the state register.
    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Self-checking bench for apb_master_ctrl. A table of per-cycle vectors covers
// zero-wait writes, a wait-stated read, an error read and back-to-back
// acceptance; hand-written sequences cover the watchdog abort, a stream of
// back-to-back writes and reset during ACCESS.
// ----------------------------------------------------------------------------
module tb_apb_master_ctrl;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int compared   = 0;
    int mismatched = 0;

    apb_master_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    // Free-running bus clock, 10 time-unit period.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // One table row: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        cmdValid;
        logic        cmdWrite;
        logic [31:0] cmdAddr;
        logic [31:0] cmdWdata;
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
        logic        expReady;
        logic        expPsel;
        logic        expPenable;
        logic        expPwrite;
        logic [31:0] expPaddr;
        logic [31:0] expPwdata;
        logic        expRspValid;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
        input logic rdy, input logic [31:0] prd, input logic perr,
        input logic eRdy, input logic eSel, input logic eEn, input logic eWr,
        input logic [31:0] eAddr, input logic [31:0] eWd,
        input logic eRv, input logic [31:0] eRd, input logic eErr);
        vec_t r;
        r.cmdValid = v;     r.cmdWrite = w;   r.cmdAddr = a;     r.cmdWdata = d;
        r.pready = rdy;     r.prdata = prd;   r.pslverr = perr;
        r.expReady = eRdy;  r.expPsel = eSel; r.expPenable = eEn; r.expPwrite = eWr;
        r.expPaddr = eAddr; r.expPwdata = eWd;
        r.expRspValid = eRv; r.expRdata = eRd; r.expErr = eErr;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_valid = v.cmdValid;
        cmd_write = v.cmdWrite;
        cmd_addr  = v.cmdAddr;
        cmd_wdata = v.cmdWdata;
        PREADY    = v.pready;
        PRDATA    = v.prdata;
        PSLVERR   = v.pslverr;
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        int pulses;
        int accessCycles;
        int cycles;

        // Row format: inputs (valid write addr wdata pready prdata pslverr),
        // then outputs after the edge (ready psel penable pwrite paddr pwdata
        // rsp_valid rsp_rdata rsp_err).
        // Zero-wait write to 0x10.
        vecs[0]  = mk(1, 1, 32'h10, 32'hA5A5_0001, 1, 32'h0,         0,  0, 1, 0, 1, 32'h10, 32'hA5A5_0001, 0, 32'h0,         0);
        vecs[1]  = mk(0, 0, 32'h0,  32'h0,         1, 32'h0,         0,  0, 1, 1, 1, 32'h10, 32'hA5A5_0001, 0, 32'h0,         0);
        vecs[2]  = mk(0, 0, 32'h0,  32'h0,         1, 32'hDEAD_BEEF, 0,  1, 0, 0, 1, 32'h10, 32'hA5A5_0001, 1, 32'h0,         0);
        vecs[3]  = mk(0, 0, 32'h0,  32'h0,         0, 32'h0,         0,  1, 0, 0, 1, 32'h10, 32'hA5A5_0001, 0, 32'h0,         0);
        // Read of 0x04 with three wait states.
        vecs[4]  = mk(1, 0, 32'h04, 32'h1234,      0, 32'h0,         0,  0, 1, 0, 0, 32'h04, 32'h1234,      0, 32'h0,         0);
        vecs[5]  = mk(0, 0, 32'h0,  32'h0,         0, 32'h77,        0,  0, 1, 1, 0, 32'h04, 32'h1234,      0, 32'h0,         0);
        vecs[6]  = mk(0, 0, 32'h0,  32'h0,         0, 32'h77,        0,  0, 1, 1, 0, 32'h04, 32'h1234,      0, 32'h0,         0);
        vecs[7]  = mk(0, 0, 32'h0,  32'h0,         0, 32'h77,        1,  0, 1, 1, 0, 32'h04, 32'h1234,      0, 32'h0,         0);
        vecs[8]  = mk(0, 0, 32'h0,  32'h0,         0, 32'h77,        0,  0, 1, 1, 0, 32'h04, 32'h1234,      0, 32'h0,         0);
        vecs[9]  = mk(0, 0, 32'h0,  32'h0,         1, 32'hFF,        0,  1, 0, 0, 0, 32'h04, 32'h1234,      1, 32'hFF,        0);
        vecs[10] = mk(0, 0, 32'h0,  32'h0,         1, 32'hEE,        1,  1, 0, 0, 0, 32'h04, 32'h1234,      0, 32'hFF,        0);
        // Read with PSLVERR; PREADY/PSLVERR during SETUP must be ignored.
        vecs[11] = mk(1, 0, 32'h20, 32'h0,         0, 32'h0,         0,  0, 1, 0, 0, 32'h20, 32'h0,         0, 32'hFF,        0);
        vecs[12] = mk(0, 0, 32'h0,  32'h0,         1, 32'h11,        1,  0, 1, 1, 0, 32'h20, 32'h0,         0, 32'hFF,        0);
        vecs[13] = mk(0, 0, 32'h0,  32'h0,         1, 32'hBAD0_0001, 1,  1, 0, 0, 0, 32'h20, 32'h0,         1, 32'hBAD0_0001, 1);
        // Next command accepted in the response cycle; cmd_* ignored in ACCESS.
        vecs[14] = mk(1, 0, 32'h30, 32'hCAFE,      0, 32'h0,         0,  0, 1, 0, 0, 32'h30, 32'hCAFE,      0, 32'hBAD0_0001, 1);
        vecs[15] = mk(1, 1, 32'h99, 32'h9999,      0, 32'h0,         0,  0, 1, 1, 0, 32'h30, 32'hCAFE,      0, 32'hBAD0_0001, 1);
        vecs[16] = mk(0, 1, 32'h99, 32'h9999,      1, 32'h5A5A,      0,  1, 0, 0, 0, 32'h30, 32'hCAFE,      1, 32'h5A5A,      0);
        vecs[17] = mk(0, 0, 32'h0,  32'h0,         0, 32'h0,         0,  1, 0, 0, 0, 32'h30, 32'hCAFE,      0, 32'h5A5A,      0);

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state.
        tick();
        tick();
        checkOutput("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset.psel",      32'(PSEL),      32'd0);
        checkOutput("reset.penable",   32'(PENABLE),   32'd0);
        checkOutput("reset.pwrite",    32'(PWRITE),    32'd0);
        checkOutput("reset.paddr",     PADDR,          32'h0);
        checkOutput("reset.pwdata",    PWDATA,         32'h0);
        checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset.rsp_rdata", rsp_rdata,      32'h0);
        checkOutput("reset.rsp_err",   32'(rsp_err),   32'd0);
        PRESETn = 1'b1;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("row%0d.cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("row%0d.psel", i),      32'(PSEL),      32'(vecs[i].expPsel));
            checkOutput($sformatf("row%0d.penable", i),   32'(PENABLE),   32'(vecs[i].expPenable));
            checkOutput($sformatf("row%0d.pwrite", i),    32'(PWRITE),    32'(vecs[i].expPwrite));
            checkOutput($sformatf("row%0d.paddr", i),     PADDR,          vecs[i].expPaddr);
            checkOutput($sformatf("row%0d.pwdata", i),    PWDATA,         vecs[i].expPwdata);
            checkOutput($sformatf("row%0d.rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].expRspValid));
            checkOutput($sformatf("row%0d.rsp_rdata", i), rsp_rdata,      vecs[i].expRdata);
            checkOutput($sformatf("row%0d.rsp_err", i),   32'(rsp_err),   32'(vecs[i].expErr));
        end

        // Watchdog: PREADY stuck low, abort after 16 ACCESS cycles.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h1357_9BDF;
        tick();
        checkOutput("timeout.setup_psel", 32'(PSEL), 32'd1);
        cmd_valid    = 1'b0;
        accessCycles = 0;
        cycles       = 0;
        while (PSEL && cycles < 40) begin
            tick();
            cycles++;
            if (PENABLE) accessCycles++;
        end
        checkOutput("timeout.access_cycles", 32'(accessCycles), 32'd16);
        checkOutput("timeout.psel",          32'(PSEL),         32'd0);
        checkOutput("timeout.rsp_valid",     32'(rsp_valid),    32'd1);
        checkOutput("timeout.rsp_err",       32'(rsp_err),      32'd1);
        checkOutput("timeout.rsp_rdata",     rsp_rdata,         32'h0);
        tick();
        checkOutput("timeout.pulse_end",     32'(rsp_valid),    32'd0);

        // Back-to-back writes with cmd_valid held high: period 3.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h100;
        cmd_wdata = 32'h1000;
        PREADY    = 1'b1;
        pulses    = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            checkOutput($sformatf("b2b.psel%0d", e),      32'(PSEL),      32'((e % 3) != 2));
            checkOutput($sformatf("b2b.rsp_valid%0d", e), 32'(rsp_valid), 32'((e % 3) == 2));
            if (rsp_valid) pulses++;
            if ((e % 3) == 0) begin
                checkOutput($sformatf("b2b.paddr%0d", e), PADDR, 32'h100 + 32'(4 * (e / 3)));
                cmd_addr = 32'h100 + 32'(4 * (e / 3 + 1));
            end
            if (e == 9) cmd_valid = 1'b0;
        end
        checkOutput("b2b.pulses", 32'(pulses), 32'd4);

        // Reset asserted during ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        PREADY    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        checkOutput("rstmid.in_access", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        checkOutput("rstmid.psel",      32'(PSEL),      32'd0);
        checkOutput("rstmid.penable",   32'(PENABLE),   32'd0);
        checkOutput("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        PREADY = 1'b1;
        tick();
        PRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("rstmid.after%0d.rsp_valid", c), 32'(rsp_valid), 32'd0);
            checkOutput($sformatf("rstmid.after%0d.cmd_ready", c), 32'(cmd_ready), 32'd1);
            checkOutput($sformatf("rstmid.after%0d.psel", c),      32'(PSEL),      32'd0);
            checkOutput($sformatf("rstmid.after%0d.paddr", c),     PADDR,          32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
